// File: rtl/bip_defs.sv
// Shared encodings for the BIP control path: opcodes, accumulator/ALU selects,
// FSM state codes and the decoded-instruction record.
package bip_defs;

   typedef enum logic [4:0] {
      OP_HLT  = 5'b00000,
      OP_STO  = 5'b00001,
      OP_LD   = 5'b00010,
      OP_LDI  = 5'b00011,
      OP_ADD  = 5'b00100,
      OP_ADDI = 5'b00101,
      OP_SUB  = 5'b00110,
      OP_SUBI = 5'b00111,
      OP_AND  = 5'b01000,
      OP_ANDI = 5'b01001,
      OP_OR   = 5'b01010,
      OP_ORI  = 5'b01011,
      OP_XOR  = 5'b01100,
      OP_XORI = 5'b01101,
      OP_BEQ  = 5'b01110,
      OP_BNE  = 5'b01111,
      OP_JMP  = 5'b10000
   } opcode_e;

   typedef enum logic [1:0] {
      SELA_RAM  = 2'b00,
      SELA_IMM  = 2'b01,
      SELA_ALU  = 2'b10,
      SELA_HOLD = 2'b11
   } sel_a_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXEC    = 3'd3,
      ST_MEMWAIT = 3'd4,
      ST_HALT    = 3'd5
   } state_e;

   // What EXEC has to do with the instruction, independent of its exact opcode.
   typedef enum logic [2:0] {
      CLS_HLT = 3'd0,
      CLS_IMM = 3'd1,
      CLS_STO = 3'd2,
      CLS_MEM = 3'd3,
      CLS_BEQ = 3'd4,
      CLS_BNE = 3'd5,
      CLS_JMP = 3'd6,
      CLS_ILL = 3'd7
   } op_class_e;

   typedef struct packed {
      op_class_e cls;
      alu_op_e   alu_op;
      sel_a_e    sel_a;
      logic      sel_b;
      logic      legal;
   } dec_t;

   // ALU instruction taking its B operand from RAM (mem = 1) or the immediate.
   function automatic dec_t dec_alu(input alu_op_e op, input logic mem);
      dec_t d;
      d.cls    = mem ? CLS_MEM : CLS_IMM;
      d.alu_op = op;
      d.sel_a  = SELA_ALU;
      d.sel_b  = ~mem;
      d.legal  = 1'b1;
      return d;
   endfunction

endpackage

// File: rtl/bip_opdec.sv
// Combinational opcode classifier: maps the registered opcode to its class,
// ALU operation, accumulator/B-operand selects and a legal flag.
module bip_opdec
   import bip_defs::*;
#(
   parameter int OPCODE = 5
) (
   input  logic [OPCODE-1:0] opcode,
   output dec_t              dec
);

   logic       upper_clear;
   logic [4:0] low;

   // Any set bit above the 5-bit opcode field makes the instruction illegal.
   assign upper_clear = ((opcode >> 5) == '0);
   assign low         = opcode[4:0];

   always_comb begin
      // NOTE: dec gets a complete default first, so no branch can infer a latch.
      dec = '{cls: CLS_ILL, alu_op: ALU_ADD, sel_a: SELA_HOLD, sel_b: 1'b0, legal: 1'b0};
      if (upper_clear) begin
         case (low)
            OP_HLT:  dec = '{cls: CLS_HLT, alu_op: ALU_ADD, sel_a: SELA_HOLD, sel_b: 1'b0, legal: 1'b1};
            OP_STO:  dec = '{cls: CLS_STO, alu_op: ALU_ADD, sel_a: SELA_HOLD, sel_b: 1'b0, legal: 1'b1};
            OP_LD:   dec = '{cls: CLS_MEM, alu_op: ALU_ADD, sel_a: SELA_RAM,  sel_b: 1'b0, legal: 1'b1};
            OP_LDI:  dec = '{cls: CLS_IMM, alu_op: ALU_ADD, sel_a: SELA_IMM,  sel_b: 1'b1, legal: 1'b1};
            OP_ADD:  dec = dec_alu(ALU_ADD, 1'b1);
            OP_ADDI: dec = dec_alu(ALU_ADD, 1'b0);
            OP_SUB:  dec = dec_alu(ALU_SUB, 1'b1);
            OP_SUBI: dec = dec_alu(ALU_SUB, 1'b0);
            OP_AND:  dec = dec_alu(ALU_AND, 1'b1);
            OP_ANDI: dec = dec_alu(ALU_AND, 1'b0);
            OP_OR:   dec = dec_alu(ALU_OR,  1'b1);
            OP_ORI:  dec = dec_alu(ALU_OR,  1'b0);
            OP_XOR:  dec = dec_alu(ALU_XOR, 1'b1);
            OP_XORI: dec = dec_alu(ALU_XOR, 1'b0);
            OP_BEQ:  dec = '{cls: CLS_BEQ, alu_op: ALU_ADD, sel_a: SELA_HOLD, sel_b: 1'b0, legal: 1'b1};
            OP_BNE:  dec = '{cls: CLS_BNE, alu_op: ALU_ADD, sel_a: SELA_HOLD, sel_b: 1'b0, legal: 1'b1};
            OP_JMP:  dec = '{cls: CLS_JMP, alu_op: ALU_ADD, sel_a: SELA_HOLD, sel_b: 1'b0, legal: 1'b1};
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/bip_control_fsm.sv
// BIP control unit: fetch/decode/execute sequencer with bounded RAM wait,
// sticky halt/error flags and a saturating retired-instruction counter.
module bip_control_fsm
   import bip_defs::*;
#(
   parameter int OPCODE  = 5,
   parameter int ALUOP   = 3,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_Start,
   input  logic [OPCODE-1:0] i_Opcode,
   input  logic              i_AccZero,
   input  logic              i_RamValid,
   output logic              o_RdRom,
   output logic              o_WrPC,
   output logic              o_PcSel,
   output logic [1:0]        o_SelA,
   output logic              o_SelB,
   output logic [ALUOP-1:0]  o_AluOp,
   output logic              o_WrAcc,
   output logic              o_WrRam,
   output logic              o_RdRam,
   output logic              o_Halt,
   output logic              o_IllegalOp,
   output logic              o_BusErr,
   output logic [CNT_W-1:0]  o_InstrCount
);

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e              state;
   logic [OPCODE-1:0]   opcode_q;
   logic [WAIT_W-1:0]   wait_q;
   logic                illegal_q;
   logic                bus_err_q;
   logic [CNT_W-1:0]    count_q;
   dec_t                dec;

   // Only the registered opcode is decoded; i_Opcode never reaches an output.
   bip_opdec #(.OPCODE(OPCODE)) u_opdec (
      .opcode (opcode_q),
      .dec    (dec)
   );

   // NOTE: non-blocking assignments make every register see pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         opcode_q  <= '0;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:   if (i_Start) state <= ST_FETCH;
            ST_FETCH:  state <= ST_DECODE;
            ST_DECODE: begin
               opcode_q <= i_Opcode;
               state    <= ST_EXEC;
            end
            ST_EXEC: begin
               case (dec.cls)
                  CLS_MEM: begin
                     wait_q <= '0;
                     state  <= ST_MEMWAIT;
                  end
                  CLS_HLT: state <= ST_HALT;
                  CLS_ILL: begin
                     illegal_q <= 1'b1;
                     state     <= ST_HALT;
                  end
                  default: state <= ST_FETCH;
               endcase
            end
            ST_MEMWAIT: begin
               // Valid data in the last allowed cycle still completes the access.
               if (i_RamValid) begin
                  state <= ST_FETCH;
               end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                  bus_err_q <= 1'b1;
                  state     <= ST_HALT;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            ST_HALT:   state <= ST_HALT;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         count_q <= '0;
      else if (o_WrPC && (count_q != '1))
         count_q <= count_q + CNT_W'(1);
   end

   always_comb begin
      o_RdRom = 1'b0;
      o_WrPC  = 1'b0;
      o_PcSel = 1'b0;
      o_SelA  = SELA_HOLD;
      o_SelB  = 1'b0;
      o_AluOp = '0;
      o_WrAcc = 1'b0;
      o_WrRam = 1'b0;
      o_RdRam = 1'b0;
      case (state)
         ST_FETCH: o_RdRom = 1'b1;
         ST_EXEC: begin
            case (dec.cls)
               CLS_IMM: begin
                  o_WrAcc = 1'b1;
                  o_WrPC  = 1'b1;
                  o_SelA  = dec.sel_a;
                  o_SelB  = dec.sel_b;
                  o_AluOp = ALUOP'(dec.alu_op);
               end
               CLS_STO: begin
                  o_WrRam = 1'b1;
                  o_WrPC  = 1'b1;
               end
               CLS_MEM: o_RdRam = 1'b1;
               CLS_BEQ: begin
                  o_WrPC  = 1'b1;
                  o_PcSel = i_AccZero;
               end
               CLS_BNE: begin
                  o_WrPC  = 1'b1;
                  o_PcSel = ~i_AccZero;
               end
               CLS_JMP: begin
                  o_WrPC  = 1'b1;
                  o_PcSel = 1'b1;
               end
               default: ;
            endcase
         end
         ST_MEMWAIT: begin
            o_RdRam = 1'b1;
            if (i_RamValid) begin
               o_WrAcc = 1'b1;
               o_WrPC  = 1'b1;
               o_SelA  = dec.sel_a;
               o_SelB  = dec.sel_b;
               o_AluOp = ALUOP'(dec.alu_op);
            end
         end
         default: ;
      endcase
   end

   assign o_Halt       = (state == ST_HALT);
   assign o_IllegalOp  = illegal_q | ((state == ST_EXEC) && !dec.legal);
   assign o_BusErr     = bus_err_q;
   assign o_InstrCount = count_q;

endmodule

// File: tb/tb_bip_control_fsm.sv
// Directed bench for bip_control_fsm; a narrow counter exposes saturation quickly.
module tb_bip_control_fsm;
   import bip_defs::*;

   localparam int OPCODE  = 5;
   localparam int ALUOP   = 3;
   localparam int TIMEOUT = 15;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              i_clk = 1'b0;
   logic              i_rst_n = 1'b0;
   logic              i_Start = 1'b0;
   logic [OPCODE-1:0] i_Opcode = '0;
   logic              i_AccZero = 1'b0;
   logic              i_RamValid = 1'b0;
   logic              o_RdRom, o_WrPC, o_PcSel, o_SelB, o_WrAcc, o_WrRam, o_RdRam;
   logic              o_Halt, o_IllegalOp, o_BusErr;
   logic [1:0]        o_SelA;
   logic [ALUOP-1:0]  o_AluOp;
   logic [CNT_W-1:0]  o_InstrCount;

   int vectors = 0;
   int miscompares = 0;
   int exp_count = 0;

   logic [4:0] strb;
   assign strb = {o_RdRom, o_WrPC, o_WrAcc, o_WrRam, o_RdRam};

   bip_control_fsm #(.OPCODE(OPCODE), .ALUOP(ALUOP), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_Start(i_Start), .i_Opcode(i_Opcode),
      .i_AccZero(i_AccZero), .i_RamValid(i_RamValid), .o_RdRom(o_RdRom), .o_WrPC(o_WrPC),
      .o_PcSel(o_PcSel), .o_SelA(o_SelA), .o_SelB(o_SelB), .o_AluOp(o_AluOp),
      .o_WrAcc(o_WrAcc), .o_WrRam(o_WrRam), .o_RdRam(o_RdRam), .o_Halt(o_Halt),
      .o_IllegalOp(o_IllegalOp), .o_BusErr(o_BusErr), .o_InstrCount(o_InstrCount)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   task automatic retire();
      if (exp_count < CNT_MAX) exp_count++;
   endtask

   // From FETCH: present op during DECODE, then scramble the bus once in EXEC.
   task automatic run_to_exec(input logic [4:0] op);
      tick();
      i_Opcode = OPCODE'(op);
      tick();
      i_Opcode = '1;
   endtask

   task automatic test_reset();
      #3;
      vectors++;
      if ({strb, o_PcSel, o_SelB, o_SelA, o_AluOp, o_Halt, o_IllegalOp, o_BusErr} !== {7'b0, 2'b11, 6'b0}) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b expected %b",
                  {strb, o_PcSel, o_SelB, o_SelA, o_AluOp, o_Halt, o_IllegalOp, o_BusErr}, {7'b0, 2'b11, 6'b0});
      end
      vectors++;
      if (o_InstrCount !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_count: got %0d expected 0", o_InstrCount);
      end
      #5 i_rst_n = 1'b1;
      tick();
      tick();
      vectors++;
      if ({strb, o_SelA} !== 7'b0000011) begin
         miscompares++;
         $display("FAIL idle_hold: got %b expected 0000011", {strb, o_SelA});
      end
   endtask

   task automatic test_ldi();
      i_Start = 1'b1;
      tick();
      i_Start = 1'b0;
      #1;
      vectors++;
      if ({strb, o_SelA} !== 7'b1000011) begin
         miscompares++;
         $display("FAIL fetch_strobe: got %b expected 1000011", {strb, o_SelA});
      end
      run_to_exec(OP_LDI);
      #1;
      vectors++;
      if ({o_SelA, o_WrAcc, o_WrPC, o_PcSel, o_WrRam, o_RdRam, o_RdRom} !== 8'b01110000) begin
         miscompares++;
         $display("FAIL ldi_exec: got %b expected 01110000",
                  {o_SelA, o_WrAcc, o_WrPC, o_PcSel, o_WrRam, o_RdRam, o_RdRom});
      end
      tick();
      retire();
      #1;
      vectors++;
      if ({o_RdRom, o_InstrCount} !== {1'b1, CNT_W'(exp_count)}) begin
         miscompares++;
         $display("FAIL ldi_retire: got rdrom=%b count=%0d expected rdrom=1 count=%0d",
                  o_RdRom, o_InstrCount, exp_count);
      end
   endtask

   task automatic test_imm();
      logic [4:0] ops [5]  = '{OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI};
      logic [2:0] alus [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
      for (int i = 0; i < 5; i++) begin
         run_to_exec(ops[i]);
         #1;
         vectors++;
         if ({o_SelA, o_SelB, o_AluOp, o_WrAcc, o_WrPC, o_PcSel, o_RdRam} !== {2'b10, 1'b1, alus[i], 4'b1100}) begin
            miscompares++;
            $display("FAIL imm_exec[%0d]: got %b expected %b", i,
                     {o_SelA, o_SelB, o_AluOp, o_WrAcc, o_WrPC, o_PcSel, o_RdRam},
                     {2'b10, 1'b1, alus[i], 4'b1100});
         end
         tick();
         retire();
         #1;
         vectors++;
         if (o_InstrCount !== CNT_W'(exp_count)) begin
            miscompares++;
            $display("FAIL imm_count[%0d]: got %0d expected %0d", i, o_InstrCount, exp_count);
         end
      end
   endtask

   task automatic test_sto();
      run_to_exec(OP_STO);
      #1;
      vectors++;
      if ({strb, o_PcSel} !== 6'b010100) begin
         miscompares++;
         $display("FAIL sto_exec: got %b expected 010100", {strb, o_PcSel});
      end
      tick();
      retire();
   endtask

   // RamValid low for EXEC and two MEMWAIT cycles, high in the third.
   task automatic test_mem_add();
      int rd_cycles = 0;
      i_RamValid = 1'b0;
      run_to_exec(OP_ADD);
      for (int cyc = 0; cyc < 4; cyc++) begin
         if (cyc > 0) tick();
         if (cyc == 3) i_RamValid = 1'b1;
         #1;
         if (o_RdRam === 1'b1) rd_cycles++;
         vectors++;
         if (cyc < 3) begin
            if ({o_WrAcc, o_WrPC, o_SelA} !== 4'b0011) begin
               miscompares++;
               $display("FAIL add_wait[%0d]: got %b expected 0011", cyc, {o_WrAcc, o_WrPC, o_SelA});
            end
         end else if ({o_WrAcc, o_WrPC, o_SelA, o_SelB, o_AluOp} !== 8'b11100000) begin
            miscompares++;
            $display("FAIL add_valid: got %b expected 11100000", {o_WrAcc, o_WrPC, o_SelA, o_SelB, o_AluOp});
         end
      end
      tick();
      i_RamValid = 1'b0;
      retire();
      #1;
      vectors++;
      if (rd_cycles !== 4) begin
         miscompares++;
         $display("FAIL add_rdram_len: got %0d expected 4", rd_cycles);
      end
      vectors++;
      if ({o_RdRam, o_RdRom, o_InstrCount} !== {2'b01, CNT_W'(exp_count)}) begin
         miscompares++;
         $display("FAIL add_saturate: got rdram=%b rdrom=%b count=%0d expected 0 1 %0d",
                  o_RdRam, o_RdRom, o_InstrCount, exp_count);
      end
   endtask

   task automatic test_branches();
      logic [4:0] ops [5] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE, OP_JMP};
      logic       acc [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       pcs [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         run_to_exec(ops[i]);
         i_AccZero = acc[i];
         #1;
         vectors++;
         if ({o_WrPC, o_PcSel, o_WrAcc, o_WrRam, o_RdRam} !== {1'b1, pcs[i], 3'b000}) begin
            miscompares++;
            $display("FAIL branch[%0d]: got %b expected %b", i,
                     {o_WrPC, o_PcSel, o_WrAcc, o_WrRam, o_RdRam}, {1'b1, pcs[i], 3'b000});
         end
         tick();
         retire();
         i_AccZero = 1'b0;
      end
   endtask

   // Data valid in the last permitted MEMWAIT cycle must beat the timeout.
   task automatic test_valid_last_cycle();
      run_to_exec(OP_LD);
      for (int k = 1; k <= TIMEOUT; k++) begin
         tick();
         if (k == TIMEOUT) i_RamValid = 1'b1;
      end
      #1;
      vectors++;
      if ({o_WrAcc, o_WrPC, o_SelA, o_SelB, o_RdRam} !== 6'b110001) begin
         miscompares++;
         $display("FAIL ld_last_valid: got %b expected 110001", {o_WrAcc, o_WrPC, o_SelA, o_SelB, o_RdRam});
      end
      tick();
      i_RamValid = 1'b0;
      retire();
      #1;
      vectors++;
      if ({o_Halt, o_BusErr, o_RdRom} !== 3'b001) begin
         miscompares++;
         $display("FAIL ld_last_next: got %b expected 001", {o_Halt, o_BusErr, o_RdRom});
      end
   endtask

   task automatic test_reset_memwait();
      run_to_exec(OP_LD);
      tick();
      #1 i_rst_n = 1'b0;
      #1;
      vectors++;
      if ({strb, o_PcSel, o_SelB, o_SelA, o_AluOp, o_Halt, o_IllegalOp, o_BusErr, o_InstrCount} !== {7'b0, 2'b11, 6'b0, 3'd0}) begin
         miscompares++;
         $display("FAIL async_reset: got %b expected %b",
                  {strb, o_PcSel, o_SelB, o_SelA, o_AluOp, o_Halt, o_IllegalOp, o_BusErr, o_InstrCount},
                  {7'b0, 2'b11, 6'b0, 3'd0});
      end
      #1 i_rst_n = 1'b1;
      exp_count = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if ({strb, o_SelA} !== 7'b0000011) begin
            miscompares++;
            $display("FAIL post_reset_idle[%0d]: got %b expected 0000011", k, {strb, o_SelA});
         end
      end
      i_Start = 1'b1;
      tick();
      i_Start = 1'b0;
      #1;
      vectors++;
      if (o_RdRom !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_fetch: got %b expected 1", o_RdRom);
      end
   endtask

   task automatic test_timeout();
      run_to_exec(OP_LDI);
      tick();
      retire();
      run_to_exec(OP_LD);
      for (int k = 1; k <= TIMEOUT; k++) begin
         tick();
         vectors++;
         if ({o_RdRam, o_Halt, o_BusErr} !== 3'b100) begin
            miscompares++;
            $display("FAIL ld_wait[%0d]: got %b expected 100", k, {o_RdRam, o_Halt, o_BusErr});
         end
      end
      tick();
      #1;
      vectors++;
      if ({o_Halt, o_BusErr, o_IllegalOp, strb, o_SelA} !== 10'b1100000011) begin
         miscompares++;
         $display("FAIL timeout_halt: got %b expected 1100000011", {o_Halt, o_BusErr, o_IllegalOp, strb, o_SelA});
      end
      vectors++;
      if (o_InstrCount !== CNT_W'(exp_count)) begin
         miscompares++;
         $display("FAIL timeout_count: got %0d expected %0d", o_InstrCount, exp_count);
      end
      i_Start = 1'b1;
      tick();
      tick();
      i_Start = 1'b0;
      #1;
      vectors++;
      if ({o_Halt, o_BusErr, o_RdRom} !== 3'b110) begin
         miscompares++;
         $display("FAIL timeout_sticky: got %b expected 110", {o_Halt, o_BusErr, o_RdRom});
      end
   endtask

   task automatic test_illegal();
      #1 i_rst_n = 1'b0;
      #1;
      vectors++;
      if ({o_Halt, o_BusErr, o_IllegalOp} !== 3'b000) begin
         miscompares++;
         $display("FAIL halt_reset: got %b expected 000", {o_Halt, o_BusErr, o_IllegalOp});
      end
      #1 i_rst_n = 1'b1;
      exp_count = 0;
      i_Start = 1'b1;
      tick();
      i_Start = 1'b0;
      run_to_exec(5'b11111);
      #1;
      vectors++;
      if ({o_WrPC, o_PcSel, o_WrAcc, o_WrRam, o_RdRam} !== 5'b00000) begin
         miscompares++;
         $display("FAIL illegal_exec: got %b expected 00000", {o_WrPC, o_PcSel, o_WrAcc, o_WrRam, o_RdRam});
      end
      tick();
      #1;
      vectors++;
      if ({o_Halt, o_IllegalOp, o_BusErr, strb, o_SelA} !== 10'b1100000011) begin
         miscompares++;
         $display("FAIL illegal_halt: got %b expected 1100000011", {o_Halt, o_IllegalOp, o_BusErr, strb, o_SelA});
      end
      i_Start = 1'b1;
      repeat (3) tick();
      i_Start = 1'b0;
      #1;
      vectors++;
      if ({o_Halt, o_IllegalOp, o_RdRom, o_InstrCount} !== {3'b110, 3'd0}) begin
         miscompares++;
         $display("FAIL illegal_sticky: got %b expected 110000", {o_Halt, o_IllegalOp, o_RdRom, o_InstrCount});
      end
      #1 i_rst_n = 1'b0;
      #1;
      vectors++;
      if ({o_Halt, o_IllegalOp} !== 2'b00) begin
         miscompares++;
         $display("FAIL illegal_clear: got %b expected 00", {o_Halt, o_IllegalOp});
      end
      #1 i_rst_n = 1'b1;
   endtask

   task automatic test_hlt();
      i_Start = 1'b1;
      tick();
      i_Start = 1'b0;
      run_to_exec(OP_HLT);
      #1;
      vectors++;
      if ({o_WrPC, o_Halt} !== 2'b00) begin
         miscompares++;
         $display("FAIL hlt_exec: got %b expected 00", {o_WrPC, o_Halt});
      end
      tick();
      #1;
      vectors++;
      if ({o_Halt, o_IllegalOp, o_BusErr} !== 3'b100) begin
         miscompares++;
         $display("FAIL hlt_halt: got %b expected 100", {o_Halt, o_IllegalOp, o_BusErr});
      end
   endtask

   initial begin
      test_reset();
      test_ldi();
      test_imm();
      test_sto();
      test_mem_add();
      test_branches();
      test_valid_last_cycle();
      test_reset_memwait();
      test_timeout();
      test_illegal();
      test_hlt();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bip_control_fsm.md
BIP_CONTROL_FSM -- requirements
Module: bip_control_fsm

Interface
REQ-001 Parameter OPCODE, default 5: opcode width, minimum 5.
REQ-002 Parameter ALUOP, default 3: ALU operation select width.
REQ-003 Parameter TIMEOUT, default 15: maximum cycles spent waiting for i_RamValid.
REQ-004 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-005 Port list, one per line: name, direction, width, meaning.
- i_clk  in  1  single clock; all state changes on its rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_Start  in  1  leave IDLE and begin fetching.
- i_Opcode  in  OPCODE  opcode field of the instruction bus.
- i_AccZero  in  1  accumulator equals zero.
- i_RamValid  in  1  data-memory read data valid.
- o_RdRom  out  1  instruction-memory read strobe.
- o_WrPC  out  1  PC update strobe.
- o_PcSel  out  1  0 = PC+1, 1 = operand (branch target).
- o_SelA  out  2  accumulator source: 00 RAM, 01 immediate, 10 ALU, 11 hold.
- o_SelB  out  1  ALU B source: 0 RAM, 1 immediate.
- o_AluOp  out  ALUOP  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
- o_WrAcc  out  1  accumulator write strobe.
- o_WrRam  out  1  data-memory write strobe.
- o_RdRam  out  1  data-memory read request.
- o_Halt  out  1  sticky halted flag.
- o_IllegalOp  out  1  sticky; set when halted by an undefined opcode.
- o_BusErr  out  1  sticky; set when halted by a RAM timeout.
- o_InstrCount  out  CNT_W  retired instructions, saturating.

Function
REQ-006 Opcodes: HLT 00000, STO 00001, LD 00010, LDI 00011, ADD 00100, ADDI 00101, SUB 00110, SUBI 00111, AND 01000, ANDI 01001, OR 01010, ORI 01011, XOR 01100, XORI 01101, BEQ 01110, BNE 01111, JMP 10000.
REQ-007 Any other code, including any nonzero bit above bit 4, is illegal.
REQ-008 States: IDLE, FETCH, DECODE, EXEC, MEMWAIT, HALT.
REQ-009 IDLE: all strobes 0; the FSM moves to FETCH on i_Start=1. i_Start is ignored in every other state.
REQ-010 FETCH: o_RdRom=1 for exactly one cycle, then DECODE.
REQ-011 DECODE: i_Opcode is registered internally, then EXEC. All later decode uses the registered copy only.
REQ-012 EXEC for LDI, ADDI, SUBI, ANDI, ORI, XORI: single cycle.
- Strobes: o_WrAcc=1, o_WrPC=1, o_PcSel=0.
- Selects: LDI uses o_SelA=01; the others use o_SelA=10, o_SelB=1 and the matching o_AluOp.
- Next state: FETCH.
REQ-013 EXEC for STO: o_WrRam=1 and o_WrPC=1 for one cycle, then FETCH.
REQ-014 EXEC for LD, ADD, SUB, AND, OR, XOR: o_RdRam=1, then MEMWAIT.
- o_RdRam stays 1 throughout MEMWAIT.
- In the cycle i_RamValid=1: o_WrAcc=1, o_WrPC=1, o_SelA (00 for LD, 10 otherwise), o_SelB=0, o_AluOp are driven, then FETCH.
REQ-015 MEMWAIT timeout: a wait counter starts at 0 on entry. If TIMEOUT cycles elapse without i_RamValid, the FSM goes to HALT with o_BusErr=1. i_RamValid in the terminal cycle wins over the timeout.
REQ-016 Branches, single cycle in EXEC, o_WrPC=1:
- BEQ: o_PcSel = i_AccZero.
- BNE: o_PcSel = !i_AccZero.
- JMP: o_PcSel = 1.
- Next state: FETCH.
REQ-017 HLT: o_WrPC=0, go to HALT.
REQ-018 Illegal opcode: o_WrPC=0, o_IllegalOp=1, go to HALT.
REQ-019 HALT: o_Halt=1, all strobes 0, o_SelA=11. Only reset leaves HALT.
REQ-020 Outside the cases above: o_SelA=11 and all strobes 0.
REQ-021 o_InstrCount increments by 1 in each cycle where o_WrPC=1, and saturates at 2^CNT_W-1.
REQ-022 All outputs are functions of the registered state and opcode plus i_AccZero/i_RamValid. There is no path from i_Opcode to outputs.

Reset
REQ-023 i_rst_n=0 asynchronously forces IDLE, including mid-MEMWAIT or in HALT.
REQ-024 Reset values:
- o_SelA=11, o_AluOp=0.
- Every other output 0, including o_InstrCount, o_Halt, o_IllegalOp, o_BusErr.
- Registered opcode and wait counter cleared.
REQ-025 After reset deasserts, the FSM stays in IDLE until i_Start=1.

Structure
REQ-026 Opcode codes, SelA encodings, AluOp encodings and state codes live in the shared definitions package bip_defs.
REQ-027 Opcode classification (class, AluOp, SelA, SelB, legal) is a combinational sub-module bip_opdec instantiated once. The FSM, wait counter and instruction counter stay in bip_control_fsm.

Verification
REQ-028 Reset, then i_Start, then LDI: FETCH-DECODE-EXEC.
- In EXEC: o_SelA=01, o_WrAcc=1, o_WrPC=1.
- o_InstrCount=1 afterwards; FETCH follows.
REQ-029 ADD with i_RamValid held 0 for 3 cycles, then 1:
- o_RdRam=1 for 4 cycles.
- o_WrAcc=1, o_SelA=10, o_SelB=0, o_AluOp=000 only in the valid cycle.
REQ-030 LD with i_RamValid never asserted, TIMEOUT=15: HALT after 15 MEMWAIT cycles; o_Halt=1, o_BusErr=1, o_InstrCount unchanged.
REQ-031 BEQ and BNE, each run with i_AccZero=1 and with i_AccZero=0: o_PcSel=1/0 for BEQ and 0/1 for BNE; o_WrPC=1 in all four runs.
REQ-032 Opcode 11111: o_IllegalOp=1 and o_Halt=1, held sticky. A later i_Start does nothing; only i_rst_n=0 clears them.
REQ-033 i_rst_n pulsed low during MEMWAIT: outputs reach reset values without waiting for a clock edge; the FSM then stays in IDLE.
